// File: rtl/rom_block_fetcher_pkg.sv
// Shared definitions for the ROM block fetcher: FSM state encoding and
// the byte stride helper used to advance the ROM byte address per word.
package rom_block_fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned BYTE_BITS = 8;

    function automatic int unsigned byte_stride(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/rom_block_fetcher_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
// Flush takes priority over any write or read in the same cycle.
module rom_block_fetcher_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i && !full;
    assign do_rd   = rd_en_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_wr && !do_rd)      count_q <= count_q + (AW+1)'(1);
            else if (do_rd && !do_wr) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/rom_block_fetcher.sv
// BRAM-port initiator reading a contiguous run of ROM words and streaming them
// out in order; reads are credit-limited by free output-buffer space.
module rom_block_fetcher
    import rom_block_fetcher_pkg::*;
#(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32,
    parameter int unsigned len_width  = 16,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    input  logic [len_width-1:0]  word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  rom_clk,
    output logic                  rom_rst,
    output logic                  rom_en,
    output logic [addr_width-1:0] rom_addr,
    input  logic [data_width-1:0] rom_din
);

    localparam int unsigned STRIDE = byte_stride(data_width);
    localparam int unsigned CW     = $clog2(fifo_depth) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(fifo_depth);

    state_t                state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [len_width-1:0]  issue_left_q, issue_left_d;
    logic [len_width-1:0]  recv_left_q, recv_left_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  flush;
    logic                  hs;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  credit_ok;

    rom_block_fetcher_sync_fifo #(
        .WIDTH (data_width),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .wr_en_i   (rd_pend_q),
        .wr_data_i (rom_din),
        .rd_en_i   (hs),
        .rd_data_o (m_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Words already buffered plus the one read still returning from the ROM.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
    assign credit_ok = (occupancy < DEPTH_C);

    assign m_valid  = !fifo_empty;
    assign m_last   = m_valid && (recv_left_q == len_width'(1));
    assign hs       = m_valid && m_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_clk  = clk;
    assign rom_rst  = ~rst_n;
    assign rom_en   = issue;
    assign rom_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            rd_pend_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            recv_left_q  <= recv_left_d;
            rd_pend_q    <= rd_pend_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        recv_left_d  = recv_left_q;
        done_d       = 1'b0;
        flush        = 1'b0;
        issue        = 1'b0;

        // Abort suppresses the read strobe too, so nothing new is launched
        // into a pipeline that is being discarded.
        if (abort) begin
            state_d      = IDLE;
            flush        = 1'b1;
            issue_left_d = '0;
            recv_left_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr_d       = start_addr;
                            issue_left_d = word_count;
                            recv_left_d  = word_count;
                            state_d      = FETCH;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if ((issue_left_q != '0) && credit_ok) begin
                        issue        = 1'b1;
                        addr_d       = addr_q + addr_width'(STRIDE);
                        issue_left_d = issue_left_q - len_width'(1);
                        if (issue_left_q == len_width'(1)) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && m_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (hs) recv_left_d = recv_left_q - len_width'(1);
        end

        rd_pend_d = issue;
    end

endmodule

// File: tb/tb_rom_block_fetcher.sv
// Self-checking bench for rom_block_fetcher: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_rom_block_fetcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic        abort = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] rom_din = '0;
    logic        busy, done, m_valid, m_last, rom_clk, rom_rst, rom_en;
    logic [31:0] m_data, rom_addr;

    always #5 clk = ~clk;

    rom_block_fetcher #(
        .addr_width (32),
        .data_width (32),
        .len_width  (16),
        .fifo_depth (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .rom_clk    (rom_clk),
        .rom_rst    (rom_rst),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_din    (rom_din)
    );

    // ROM contents: byte at address a, little-endian lanes.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            b = a + 32'(i);
            w[i*8 +: 8] = b[7:0] ^ b[15:8] ^ b[31:24] ^ 8'h5A;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_din <= rom_word(rom_addr);
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model state.
    bit          m_busy = 0;
    bit          exp_done = 0;
    logic [31:0] iss_q[$];
    logic [32:0] dat_q[$];
    int          outstanding = 0;
    bit          stall_prev = 0;
    logic [31:0] held_d;
    logic        held_l;

    int          cyc = 0;
    int          issue_cnt = 0;
    int          beat_cnt = 0;
    int          start_cyc = -1;
    int          first_en_cyc = -1;
    int          last_en_cyc = -1;
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];

    always @(negedge clk) begin
        bit was_busy;
        bit hs_last;
        logic [32:0] head;
        cyc++;
        hs_last = 0;
        if (!rst_n) begin
            m_busy = 0; exp_done = 0; outstanding = 0; stall_prev = 0;
            iss_q.delete(); dat_q.delete();
        end else begin
            chk("done", done, exp_done);
            chk("busy", busy, m_busy);
            chk("rom_rst", rom_rst, 1'b0);
            if (done) done_cyc = cyc;
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, held_d);
                chk("hold_last", m_last, held_l);
            end
            if (rom_en) begin
                issue_cnt++;
                addr_log.push_back(rom_addr);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                if (iss_q.size() == 0) chk("spurious_rom_en", 1'b1, 1'b0);
                else chk("rom_addr", rom_addr, iss_q.pop_front());
                outstanding++;
                chk("credit", outstanding <= DEPTH, 1'b1);
            end
            if (m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (dat_q.size() == 0) chk("spurious_valid", 1'b1, 1'b0);
                else begin
                    head = dat_q[0];
                    chk("m_data", m_data, head[31:0]);
                    chk("m_last", m_last, head[32]);
                    if (m_ready) begin
                        void'(dat_q.pop_front());
                        data_log.push_back(m_data);
                        beat_cnt++;
                        outstanding--;
                        hs_last = head[32];
                    end
                end
            end else begin
                chk("m_last_idle", m_last, 1'b0);
            end

            exp_done   = 0;
            stall_prev = m_valid && !m_ready && !abort;
            held_d     = m_data;
            held_l     = m_last;
            was_busy   = m_busy;
            if (abort) begin
                m_busy = 0; outstanding = 0;
                iss_q.delete(); dat_q.delete();
            end else begin
                if (hs_last) begin
                    exp_done = 1;
                    m_busy   = 0;
                end
                if (!was_busy && start) begin
                    start_cyc = cyc;
                    if (word_count != 0) begin
                        m_busy = 1;
                        for (int i = 0; i < int'(word_count); i++) begin
                            iss_q.push_back(start_addr + 32'(4 * i));
                            dat_q.push_back({(i == int'(word_count) - 1), rom_word(start_addr + 32'(4 * i))});
                        end
                    end else begin
                        exp_done = 1;
                    end
                end
            end
        end
    end

    bit rand_ready = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_ready = ($urandom % 4) != 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] wc);
        cycles(1);
        start = 1'b1; start_addr = a; word_count = wc;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin cycles(1); n++; end
        if (n >= budget) chk("timeout_idle", 1'b0, 1'b1);
        cycles(1);
        chk("model_drained", 64'(dat_q.size()), 64'd0);
    endtask

    task automatic clear_logs();
        addr_log.delete(); data_log.delete();
        first_en_cyc = -1; last_en_cyc = -1; first_valid_cyc = -1;
        done_cyc = -1; start_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_last"}, m_last, 1'b0);
        chk({tag, "_rom_en"}, rom_en, 1'b0);
        chk({tag, "_rom_addr"}, rom_addr, 32'h0);
        chk({tag, "_rom_rst"}, rom_rst, 1'b1);
    endtask

    initial begin
        int i0, b0;
        int r;
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);

        // Basic 3-word fetch with free-flowing stream.
        m_ready = 1'b1;
        clear_logs();
        do_start(32'h10, 16'd3);
        wait_idle(50);
        chk("t1_issues", 64'(addr_log.size()), 64'd3);
        if (addr_log.size() == 3) begin
            chk("t1_addr0", addr_log[0], 32'h10);
            chk("t1_addr1", addr_log[1], 32'h14);
            chk("t1_addr2", addr_log[2], 32'h18);
        end
        if (data_log.size() > 0) chk("t1_data0", data_log[0], 32'h49484B4A);
        chk("t1_en_latency", first_en_cyc - start_cyc, 1);
        chk("t1_en_back_to_back", last_en_cyc - first_en_cyc, 2);
        chk("t1_valid_latency", first_valid_cyc - start_cyc, 3);
        chk("t1_done_latency", done_cyc - start_cyc, 6);

        // Zero-length request.
        clear_logs();
        i0 = issue_cnt;
        do_start(32'h40, 16'd0);
        cycles(3);
        chk("t2_done_latency", done_cyc - start_cyc, 1);
        chk("t2_no_rom_en", issue_cnt - i0, 0);
        chk("t2_no_valid", first_valid_cyc, -1);

        // Backpressure: buffer depth bounds issued reads.
        m_ready = 1'b0;
        i0 = issue_cnt; b0 = beat_cnt;
        do_start(32'h100, 16'd8);
        cycles(15);
        chk("t3_stalled_issues", issue_cnt - i0, 4);
        chk("t3_busy_stalled", busy, 1'b1);
        m_ready = 1'b1;
        wait_idle(100);
        chk("t3_beats", beat_cnt - b0, 8);
        chk("t3_issues", issue_cnt - i0, 8);

        // Address wrap.
        clear_logs();
        do_start(32'hFFFF_FFFC, 16'd2);
        wait_idle(50);
        chk("t4_issues", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) begin
            chk("t4_addr0", addr_log[0], 32'hFFFF_FFFC);
            chk("t4_addr1", addr_log[1], 32'h0);
        end

        // Abort in cycle 2 of an 8-word fetch, then a 1-word fetch.
        m_ready = 1'b0;
        clear_logs();
        do_start(32'h200, 16'd8);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("t5_busy_after_abort", busy, 1'b0);
        chk("t5_fifo_empty", m_valid, 1'b0);
        cycles(3);
        chk("t5_still_empty", m_valid, 1'b0);
        chk("t5_no_done", done_cyc, -1);
        m_ready = 1'b1;
        clear_logs();
        do_start(32'h300, 16'd1);
        wait_idle(50);
        chk("t5_refetch_beats", 64'(data_log.size()), 64'd1);
        if (data_log.size() == 1) chk("t5_refetch_data", data_log[0], 32'h5A5B5859);

        // Reset in the middle of DRAIN.
        m_ready = 1'b0;
        do_start(32'h400, 16'd3);
        cycles(6);
        chk("t6_busy_before_reset", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        clear_logs();
        do_start(32'h10, 16'd3);
        wait_idle(50);
        chk("t6_after_reset_beats", 64'(data_log.size()), 64'd3);

        // Randomized traffic with random backpressure, stray starts and aborts.
        rand_ready = 1;
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [15:0] wc;
            a  = (($urandom % 4) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
            wc = 16'($urandom_range(0, 12));
            do_start(a, wc);
            for (int n = 0; n < 500 && busy; n++) begin
                r = $urandom % 100;
                if (r < 2) abort = 1'b1;
                else if (r < 7) begin
                    start = 1'b1; start_addr = $urandom; word_count = 16'($urandom_range(0, 5));
                end
                cycles(1);
                abort = 1'b0; start = 1'b0;
            end
            wait_idle(500);
        end
        rand_ready = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

endmodule
